// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the pong match sequencer.
package game_pkg;
   typedef enum logic [2:0] {MENU, COUNTDOWN, WAIT_SERVE, PLAY, GAME_OVER} game_state_t;
   localparam int SCORE_W = 4;
   localparam logic [1:0] WINNER_NONE = 2'd0;
   localparam logic [1:0] WINNER_P1   = 2'd1;
   localparam logic [1:0] WINNER_P2   = 2'd2;
endpackage

// File: rtl/game_flow_ctrl_if.sv
// Match-control bundle: button/point/frame inputs and the sequencer's outputs.
interface game_flow_ctrl_if;
   import game_pkg::*;
   logic               end_of_frame;
   logic               btn_start;
   logic               btn_mode;
   logic               point_p1;
   logic               point_p2;
   logic               screen_idle;
   logic               screen_multi;
   logic               serve;
   logic [1:0]         countdown;
   logic               server;
   logic [1:0]         winner;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;

   modport master (output end_of_frame, btn_start, btn_mode, point_p1, point_p2,
                   input  screen_idle, screen_multi, serve, countdown, server, winner,
                          score_p1, score_p2);
   modport slave  (input  end_of_frame, btn_start, btn_mode, point_p1, point_p2,
                   output screen_idle, screen_multi, serve, countdown, server, winner,
                          score_p1, score_p2);
endinterface

// File: rtl/game_flow_ctrl_rise_edge_det.sv
// Rising-edge detector; history resets high so a level held through reset yields no edge.
module rise_edge_det (
   input  logic clk65MHz,
   input  logic rst,
   input  logic din,
   output logic pulse
);
   logic din_q;

   always_ff @(posedge clk65MHz) begin
      if (rst) din_q <= 1'b1;
      else     din_q <= din;
   end

   assign pulse = din & ~din_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// Pong match sequencer: menu, pre-serve countdown, scoring and game-over hold.
// Define AUTO_SERVE_EN to launch the serve automatically when the countdown expires.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE    = 10,
   parameter int COUNT_STEPS  = 3,
   parameter int COUNT_FRAMES = 60,
   parameter int OVER_FRAMES  = 90
) (
   input  logic       clk65MHz,
   input  logic       rst,
   game_flow_ctrl_if.slave gif
);
   localparam int FMAX   = (COUNT_FRAMES > OVER_FRAMES) ? COUNT_FRAMES : OVER_FRAMES;
   localparam int FCNT_W = $clog2(FMAX + 1);
   localparam logic [FCNT_W-1:0]  CF_LAST  = FCNT_W'(COUNT_FRAMES - 1);
   localparam logic [FCNT_W-1:0]  OF_LIM   = FCNT_W'(OVER_FRAMES);
   localparam logic [1:0]         CD_INIT  = 2'(COUNT_STEPS);
   localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

   game_state_t        state_q, state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [1:0]         cd_q, cd_d, winner_q, winner_d;
   logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
   logic               idle_q, multi_q, multi_d, serve_q, serve_d, server_q, server_d;
   logic               start_pe;

   rise_edge_det u_start_edge (
      .clk65MHz (clk65MHz),
      .rst      (rst),
      .din      (gif.btn_start),
      .pulse    (start_pe)
   );

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         state_q  <= MENU;
         fcnt_q   <= '0;
         cd_q     <= '0;
         winner_q <= WINNER_NONE;
         s1_q     <= '0;
         s2_q     <= '0;
         idle_q   <= 1'b1;
         multi_q  <= 1'b0;
         serve_q  <= 1'b0;
         server_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fcnt_q   <= fcnt_d;
         cd_q     <= cd_d;
         winner_q <= winner_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         idle_q   <= (state_d == MENU);
         multi_q  <= multi_d;
         serve_q  <= serve_d;
         server_q <= server_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      cd_d     = cd_q;
      winner_d = winner_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      multi_d  = multi_q;
      serve_d  = 1'b0;
      server_d = server_q;
      case (state_q)
         MENU: if (start_pe) begin
            multi_d  = gif.btn_mode;
            s1_d     = '0;
            s2_d     = '0;
            winner_d = WINNER_NONE;
            server_d = 1'b0;
            cd_d     = CD_INIT;
            fcnt_d   = '0;
            state_d  = COUNTDOWN;
         end
         COUNTDOWN: if (gif.end_of_frame) begin
            if (fcnt_q == CF_LAST) begin
               fcnt_d = '0;
               cd_d   = cd_q - 2'd1;
               if (cd_q == 2'd1) begin
`ifdef AUTO_SERVE_EN
                  serve_d = 1'b1;
                  state_d = PLAY;
`else
                  state_d = WAIT_SERVE;
`endif
               end
            end else begin
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
         end
         WAIT_SERVE: if (start_pe) begin
            serve_d = 1'b1;
            state_d = PLAY;
         end
         PLAY: if (gif.point_p1 ^ gif.point_p2) begin
            // Rally loser serves next; simultaneous points are treated as noise.
            if (gif.point_p1) begin
               s1_d     = s1_q + SCORE_W'(1);
               server_d = 1'b1;
            end else begin
               s2_d     = s2_q + SCORE_W'(1);
               server_d = 1'b0;
            end
            fcnt_d = '0;
            if (s1_d == WIN || s2_d == WIN) begin
               winner_d = gif.point_p1 ? WINNER_P1 : WINNER_P2;
               state_d  = GAME_OVER;
            end else begin
               cd_d    = CD_INIT;
               state_d = COUNTDOWN;
            end
         end
         GAME_OVER: begin
            if (gif.end_of_frame && fcnt_q != OF_LIM) fcnt_d = fcnt_q + FCNT_W'(1);
            if (start_pe && fcnt_q == OF_LIM) begin
               winner_d = WINNER_NONE;
               state_d  = MENU;
            end
         end
         default: state_d = MENU;
      endcase
   end

   assign gif.screen_idle  = idle_q;
   assign gif.screen_multi = multi_q;
   assign gif.serve        = serve_q;
   assign gif.countdown    = cd_q;
   assign gif.server       = server_q;
   assign gif.winner       = winner_q;
   assign gif.score_p1     = s1_q;
   assign gif.score_p2     = s2_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short match (WIN_SCORE=3, 2 steps x 2 frames).
module tb_game_flow_ctrl;
   logic clk65MHz = 1'b0;
   logic rst      = 1'b1;
   int   vecs     = 0;
   int   errs     = 0;

   game_flow_ctrl_if gif ();

   game_flow_ctrl #(
      .WIN_SCORE    (3),
      .COUNT_STEPS  (2),
      .COUNT_FRAMES (2),
      .OVER_FRAMES  (4)
   ) dut (
      .clk65MHz (clk65MHz),
      .rst      (rst),
      .gif      (gif)
   );

   always #5 clk65MHz = ~clk65MHz;

   task automatic step();
      @(posedge clk65MHz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic frame();
      gif.end_of_frame = 1'b1;
      step();
      gif.end_of_frame = 1'b0;
   endtask

   task automatic press();
      gif.btn_start = 1'b1;
      step();
      gif.btn_start = 1'b0;
   endtask

   // Countdown of 2 steps x 2 frames, then the serve (auto or by button).
   task automatic serve_round(input string tag);
      frame(); step();
      frame(); step();
      chk({tag, "_cd_mid"}, 8'(gif.countdown), 8'd1);
      frame(); step();
      frame();
`ifdef AUTO_SERVE_EN
      chk({tag, "_serve"}, 8'(gif.serve), 8'd1);
      step();
      chk({tag, "_serve_off"}, 8'(gif.serve), 8'd0);
`else
      chk({tag, "_noserve"}, 8'(gif.serve), 8'd0);
      chk({tag, "_cd_zero"}, 8'(gif.countdown), 8'd0);
      step();
      press();
      chk({tag, "_serve"}, 8'(gif.serve), 8'd1);
      step();
      chk({tag, "_serve_off"}, 8'(gif.serve), 8'd0);
`endif
   endtask

   task automatic point(input logic p1, input logic p2);
      gif.point_p1 = p1;
      gif.point_p2 = p2;
      step();
      gif.point_p1 = 1'b0;
      gif.point_p2 = 1'b0;
   endtask

   initial begin
      gif.end_of_frame = 1'b0;
      gif.btn_start    = 1'b1;
      gif.btn_mode     = 1'b1;
      gif.point_p1     = 1'b0;
      gif.point_p2     = 1'b0;

      // Reset with start held: no edge may be seen afterwards.
      step(); step();
      rst = 1'b0;
      step(); step(); step();
      chk("rst_idle",   8'(gif.screen_idle), 8'd1);
      chk("rst_cd",     8'(gif.countdown),   8'd0);
      chk("rst_winner", 8'(gif.winner),      8'd0);
      chk("rst_score1", 8'(gif.score_p1),    8'd0);
      chk("rst_serve",  8'(gif.serve),       8'd0);
      gif.btn_start = 1'b0;
      step();
      chk("release_idle", 8'(gif.screen_idle), 8'd1);

      // Multiplayer start.
      press();
      chk("start_idle",  8'(gif.screen_idle),  8'd0);
      chk("start_multi", 8'(gif.screen_multi), 8'd1);
      chk("start_cd",    8'(gif.countdown),    8'd2);
      serve_round("r1");

      // P2 wins a rally.
      point(1'b0, 1'b1);
      chk("p2_score2", 8'(gif.score_p2),  8'd1);
      chk("p2_server", 8'(gif.server),    8'd0);
      chk("p2_cd",     8'(gif.countdown), 8'd2);
      // Point outside PLAY is ignored.
      point(1'b1, 1'b0);
      chk("cd_point_ign", 8'(gif.score_p1), 8'd0);
      serve_round("r2");

      // Simultaneous points: nothing changes, still PLAY.
      point(1'b1, 1'b1);
      chk("both_s1",    8'(gif.score_p1),  8'd0);
      chk("both_s2",    8'(gif.score_p2),  8'd1);
      chk("both_cd",    8'(gif.countdown), 8'd0);
      chk("both_serve", 8'(gif.serve),     8'd0);

      // P1 runs out the match.
      point(1'b1, 1'b0);
      chk("p1a_s1",     8'(gif.score_p1),  8'd1);
      chk("p1a_server", 8'(gif.server),    8'd1);
      chk("p1a_cd",     8'(gif.countdown), 8'd2);
      serve_round("r3");
      point(1'b1, 1'b0);
      chk("p1b_s1", 8'(gif.score_p1), 8'd2);
      serve_round("r4");
      point(1'b1, 1'b0);
      chk("win_s1",     8'(gif.score_p1), 8'd3);
      chk("win_winner", 8'(gif.winner),   8'd1);
      chk("win_cd",     8'(gif.countdown), 8'd0);

      // GAME_OVER: start ignored until 4 frames have elapsed.
      press(); step();
      chk("go_early_idle",   8'(gif.screen_idle), 8'd0);
      chk("go_early_winner", 8'(gif.winner),      8'd1);
      frame(); step(); frame(); step(); frame(); step();
      press(); step();
      chk("go_3f_idle", 8'(gif.screen_idle), 8'd0);
      frame(); step();
      press();
      chk("go_exit_idle",   8'(gif.screen_idle), 8'd1);
      chk("go_exit_winner", 8'(gif.winner),      8'd0);
      chk("go_hold_s1",     8'(gif.score_p1),    8'd3);
      chk("go_hold_s2",     8'(gif.score_p2),    8'd1);
      step();

      // Single-player match, then reset mid-PLAY.
      gif.btn_mode = 1'b0;
      press();
      chk("m2_multi", 8'(gif.screen_multi), 8'd0);
      chk("m2_s1",    8'(gif.score_p1),     8'd0);
      chk("m2_cd",    8'(gif.countdown),    8'd2);
      serve_round("r5");
      point(1'b1, 1'b0);
      serve_round("r6");
      chk("pre_rst_server", 8'(gif.server), 8'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_idle",   8'(gif.screen_idle),  8'd1);
      chk("mid_rst_s1",     8'(gif.score_p1),     8'd0);
      chk("mid_rst_server", 8'(gif.server),       8'd0);
      chk("mid_rst_cd",     8'(gif.countdown),    8'd0);
      chk("mid_rst_multi",  8'(gif.screen_multi), 8'd0);
      rst = 1'b0;
      step();
      chk("post_rst_idle", 8'(gif.screen_idle), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
